// File: rtl/hsv_pkg.sv
// Shared constants and types for the RGB-to-HSV pipeline stages.
// Channel indices, hue sector size, divider step count and hue-prep FSM encoding.
package hsv_pkg;

    localparam logic [1:0] IDX_R = 2'd0;
    localparam logic [1:0] IDX_G = 2'd1;
    localparam logic [1:0] IDX_B = 2'd2;

    localparam int unsigned HUE_SECTOR = 32'd60;
    localparam int unsigned DIV_STEPS  = 32'd14;
    localparam logic [3:0]  STEP_LAST  = 4'(DIV_STEPS - 32'd1);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_DIVIDE = 2'd1,
        ST_DONE   = 2'd2
    } hue_state_e;

    // 60*|num|: at most 60*255 = 15300, which fits in 14 bits
    function automatic logic [13:0] scale_sector(input logic [7:0] mag);
        return 14'({6'd0, mag} * 14'(HUE_SECTOR));
    endfunction

endpackage

// File: rtl/udiv_restoring.sv
// One-bit-per-step 14/8 unsigned restoring divider, MSB first.
// The caller sequences the steps; the quotient after the current step is presented combinationally.
module udiv_restoring
    import hsv_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic        step,
    input  logic        last,
    input  logic [13:0] dividend,
    input  logic [7:0]  divisor,
    output logic        done,
    output logic [13:0] quotient
);

    logic [13:0] rem_r;
    logic [13:0] quo_r;
    logic [7:0]  div_r;
    logic [14:0] trial_s;
    logic        ge_s;
    logic [13:0] rem_next_s;
    logic [13:0] quo_next_s;

    // Trial subtraction for the current step; a zero divisor just yields all ones
    always_comb begin
        trial_s    = {rem_r, quo_r[13]};
        ge_s       = (trial_s >= {7'd0, div_r});
        rem_next_s = 14'd0;
        if (ge_s) begin
            rem_next_s = 14'(trial_s - {7'd0, div_r});
        end else begin
            rem_next_s = trial_s[13:0];
        end
        quo_next_s = {quo_r[12:0], ge_s};
    end

    assign quotient = quo_next_s;
    assign done     = step & last;

    // Remainder/quotient shift register: load on start, advance on step
    always_ff @(posedge clk) begin
        if (rst) begin
            rem_r <= 14'd0;
            quo_r <= 14'd0;
            div_r <= 8'd0;
        end else if (start) begin
            rem_r <= 14'd0;
            quo_r <= dividend;
            div_r <= divisor;
        end else if (step) begin
            rem_r <= rem_next_s;
            quo_r <= quo_next_s;
        end
    end

endmodule

// File: rtl/rgb_hue_prep.sv
// Hue front end: picks the dominant channel and computes the signed in-sector
// hue offset 60*num/delta with a fixed-latency multi-cycle divider.
module rgb_hue_prep
    import hsv_pkg::*;
#(
    parameter int H_W = 10
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           ce,
    input  logic           in_valid,
    output logic           in_ready,
    input  logic [7:0]     r,
    input  logic [7:0]     g,
    input  logic [7:0]     b,
    output logic           out_valid,
    input  logic           out_ready,
    output logic [H_W-1:0] h,
    output logic [1:0]     max_index,
    output logic [7:0]     v_max,
    output logic [7:0]     delta
);

    hue_state_e     state_r;
    hue_state_e     state_next_s;
    logic           in_ready_r;
    logic           out_valid_r;
    logic [H_W-1:0] h_r;
    logic [1:0]     max_index_r;
    logic [7:0]     v_max_r;
    logic [7:0]     delta_r;
    logic           sign_r;
    logic [3:0]     cnt_r;

    logic [1:0]     idx_s;
    logic [7:0]     vmax_s;
    logic [7:0]     vmin_rg_s;
    logic [7:0]     vmin_s;
    logic [7:0]     delta_s;
    logic [8:0]     num_s;
    logic [7:0]     mag_s;
    logic           accept_s;
    logic           div_step_s;
    logic           div_last_s;
    logic           div_done_s;
    logic [13:0]    quotient_s;
    logic [13:0]    q_mag_s;
    logic [H_W-1:0] h_mag_s;
    logic [H_W-1:0] h_next_s;

    // Dominant channel with tie priority R > G > B
    always_comb begin
        idx_s  = IDX_R;
        vmax_s = r;
        if ((r >= g) && (r >= b)) begin
            idx_s  = IDX_R;
            vmax_s = r;
        end else if (g >= b) begin
            idx_s  = IDX_G;
            vmax_s = g;
        end else begin
            idx_s  = IDX_B;
            vmax_s = b;
        end
    end

    assign vmin_rg_s = (r <= g) ? r : g;
    assign vmin_s    = (vmin_rg_s <= b) ? vmin_rg_s : b;
    assign delta_s   = vmax_s - vmin_s;

    // Signed in-sector numerator for the dominant channel
    always_comb begin
        num_s = 9'd0;
        case (idx_s)
            IDX_R:   num_s = {1'b0, g} - {1'b0, b};
            IDX_G:   num_s = {1'b0, b} - {1'b0, r};
            IDX_B:   num_s = {1'b0, r} - {1'b0, g};
            default: num_s = 9'd0;
        endcase
    end

    assign mag_s      = num_s[8] ? 8'(9'd0 - num_s) : num_s[7:0];
    assign accept_s   = ce && (state_r == ST_IDLE) && in_valid;
    assign div_step_s = ce && (state_r == ST_DIVIDE);
    assign div_last_s = (cnt_r == 4'd0);

    udiv_restoring u_div (
        .clk      (clk),
        .rst      (rst),
        .start    (accept_s),
        .step     (div_step_s),
        .last     (div_last_s),
        .dividend (scale_sector(mag_s)),
        .divisor  (delta_s),
        .done     (div_done_s),
        .quotient (quotient_s)
    );

    // Gray pixels discard the (all-ones) quotient so nothing from a zero divisor leaks out
    always_comb begin
        q_mag_s = 14'd0;
        if (delta_r == 8'd0) begin
            q_mag_s = 14'd0;
        end else begin
            q_mag_s = quotient_s;
        end
        h_mag_s  = H_W'(q_mag_s);
        h_next_s = {H_W{1'b0}};
        if (sign_r) begin
            h_next_s = {H_W{1'b0}} - h_mag_s;
        end else begin
            h_next_s = h_mag_s;
        end
    end

    // Next-state logic
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (in_valid) state_next_s = ST_DIVIDE;
                else          state_next_s = ST_IDLE;
            end
            ST_DIVIDE: begin
                if (div_done_s) state_next_s = ST_DONE;
                else            state_next_s = ST_DIVIDE;
            end
            ST_DONE: begin
                if (out_ready) state_next_s = ST_DONE == ST_DONE ? ST_IDLE : ST_DONE;
                else           state_next_s = ST_DONE;
            end
            default: state_next_s = ST_IDLE;
        endcase
    end

    // State, handshake flags and result registers; everything holds while ce is low
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r     <= ST_IDLE;
            in_ready_r  <= 1'b1;
            out_valid_r <= 1'b0;
            h_r         <= {H_W{1'b0}};
            max_index_r <= IDX_R;
            v_max_r     <= 8'd0;
            delta_r     <= 8'd0;
            sign_r      <= 1'b0;
            cnt_r       <= 4'd0;
        end else if (ce) begin
            state_r     <= state_next_s;
            in_ready_r  <= (state_next_s == ST_IDLE);
            out_valid_r <= (state_next_s == ST_DONE);
            if (accept_s) begin
                sign_r      <= num_s[8];
                max_index_r <= (delta_s == 8'd0) ? IDX_R : idx_s;
                v_max_r     <= vmax_s;
                delta_r     <= delta_s;
                cnt_r       <= STEP_LAST;
            end else if (div_step_s) begin
                if (div_done_s) begin
                    h_r   <= h_next_s;
                    cnt_r <= 4'd0;
                end else begin
                    cnt_r <= cnt_r - 4'd1;
                end
            end
        end
    end

    assign in_ready  = in_ready_r;
    assign out_valid = out_valid_r;
    assign h         = h_r;
    assign max_index = max_index_r;
    assign v_max     = v_max_r;
    assign delta     = delta_r;

endmodule

// File: tb/tb_rgb_hue_prep.sv
// Self-checking bench for rgb_hue_prep: directed table, backpressure, ce stall,
// mid-divide reset and random pixels checked through a scoreboard queue.
module tb_rgb_hue_prep;

    localparam int H_W = 10;

    logic           clk = 1'b0;
    logic           rst;
    logic           ce;
    logic           in_valid;
    logic           in_ready;
    logic [7:0]     r;
    logic [7:0]     g;
    logic [7:0]     b;
    logic           out_valid;
    logic           out_ready;
    logic [H_W-1:0] h;
    logic [1:0]     max_index;
    logic [7:0]     v_max;
    logic [7:0]     delta;

    always #5 clk = ~clk;

    rgb_hue_prep #(.H_W(H_W)) dut (
        .clk       (clk),
        .rst       (rst),
        .ce        (ce),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .r         (r),
        .g         (g),
        .b         (b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .h         (h),
        .max_index (max_index),
        .v_max     (v_max),
        .delta     (delta)
    );

    typedef struct {
        logic [H_W-1:0] h;
        logic [1:0]     idx;
        logic [7:0]     vmax;
        logic [7:0]     delta;
    } exp_t;

    typedef struct {
        logic [7:0] r;
        logic [7:0] g;
        logic [7:0] b;
        exp_t       e;
    } vec_t;

    exp_t sb_q[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic vec_t mk(input logic [7:0] rr, input logic [7:0] gg, input logic [7:0] bb,
                                input logic [H_W-1:0] eh, input logic [1:0] ei,
                                input logic [7:0] ev, input logic [7:0] ed);
        vec_t v;
        v.r = rr; v.g = gg; v.b = bb;
        v.e.h = eh; v.e.idx = ei; v.e.vmax = ev; v.e.delta = ed;
        return v;
    endfunction

    // Reference: integer arithmetic, truncation toward zero
    function automatic exp_t model(input logic [7:0] rr, input logic [7:0] gg, input logic [7:0] bb);
        int   mx, mn, num, mag, q;
        exp_t e;
        if (rr >= gg && rr >= bb) begin
            e.idx = 2'd0; mx = int'(rr); num = int'(gg) - int'(bb);
        end else if (gg >= bb) begin
            e.idx = 2'd1; mx = int'(gg); num = int'(bb) - int'(rr);
        end else begin
            e.idx = 2'd2; mx = int'(bb); num = int'(rr) - int'(gg);
        end
        mn = int'(rr);
        if (int'(gg) < mn) mn = int'(gg);
        if (int'(bb) < mn) mn = int'(bb);
        e.vmax  = 8'(mx);
        e.delta = 8'(mx - mn);
        if (mx == mn) begin
            e.idx = 2'd0;
            q = 0;
        end else begin
            mag = (num < 0) ? -num : num;
            q = (60 * mag) / (mx - mn);
            if (num < 0) q = -q;
        end
        e.h = H_W'(q);
        return e;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic run_pixel(input vec_t v, input string name,
                             input int stall_at, input int stall_len, input int hold);
        exp_t x;
        int   n;
        r = v.r; g = v.g; b = v.b;
        in_valid = 1'b1;
        chk({name, " in_ready before accept"}, 32'(in_ready), 32'd1);
        sb_q.push_back(v.e);
        tick();
        in_valid = 1'b0;
        chk({name, " in_ready after accept"}, 32'(in_ready), 32'd0);
        n = 0;
        while (n < 60 && out_valid !== 1'b1) begin
            ce = (n >= stall_at && n < stall_at + stall_len) ? 1'b0 : 1'b1;
            tick();
            n++;
        end
        ce = 1'b1;
        chk({name, " latency"}, 32'(n), 32'(14 + stall_len));
        if (sb_q.size() == 0) begin
            chk({name, " scoreboard empty"}, 32'd0, 32'd1);
        end else begin
            x = sb_q.pop_front();
            chk({name, " h"}, 32'(h), 32'(x.h));
            chk({name, " max_index"}, 32'(max_index), 32'(x.idx));
            chk({name, " v_max"}, 32'(v_max), 32'(x.vmax));
            chk({name, " delta"}, 32'(delta), 32'(x.delta));
            for (int k = 0; k < hold; k++) begin
                r = ~v.r; g = ~v.g; b = ~v.b;
                in_valid = 1'b1;
                tick();
                chk({name, " hold out_valid"}, 32'(out_valid), 32'd1);
                chk({name, " hold in_ready"}, 32'(in_ready), 32'd0);
                chk({name, " hold h"}, 32'(h), 32'(x.h));
                chk({name, " hold v_max"}, 32'(v_max), 32'(x.vmax));
            end
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        chk({name, " release out_valid"}, 32'(out_valid), 32'd0);
        chk({name, " release in_ready"}, 32'(in_ready), 32'd1);
        if (hold > 0) begin
            tick();
            chk({name, " held pixel not taken"}, 32'(in_ready), 32'd1);
        end
    endtask

    vec_t tbl[12];
    vec_t rv;

    initial begin
        tbl[0]  = mk(8'd255, 8'd0,   8'd0,   10'h000, 2'd0, 8'd255, 8'd255);
        tbl[1]  = mk(8'd255, 8'd255, 8'd0,   10'h03C, 2'd0, 8'd255, 8'd255);
        tbl[2]  = mk(8'd255, 8'd0,   8'd128, 10'h3E2, 2'd0, 8'd255, 8'd255);
        tbl[3]  = mk(8'd0,   8'd255, 8'd0,   10'h000, 2'd1, 8'd255, 8'd255);
        tbl[4]  = mk(8'd100, 8'd100, 8'd100, 10'h000, 2'd0, 8'd100, 8'd0);
        tbl[5]  = mk(8'd0,   8'd0,   8'd200, 10'h000, 2'd2, 8'd200, 8'd200);
        tbl[6]  = mk(8'd10,  8'd200, 8'd50,  10'h00C, 2'd1, 8'd200, 8'd190);
        tbl[7]  = mk(8'd30,  8'd20,  8'd90,  10'h008, 2'd2, 8'd90,  8'd70);
        tbl[8]  = mk(8'd50,  8'd120, 8'd150, 10'h3D6, 2'd2, 8'd150, 8'd100);
        tbl[9]  = mk(8'd200, 8'd10,  8'd180, 10'h3CB, 2'd0, 8'd200, 8'd190);
        tbl[10] = mk(8'd0,   8'd100, 8'd100, 10'h03C, 2'd1, 8'd100, 8'd100);
        tbl[11] = mk(8'd7,   8'd7,   8'd0,   10'h03C, 2'd0, 8'd7,   8'd7);

        rst = 1'b1; ce = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
        r = 8'd0; g = 8'd0; b = 8'd0;
        tick();
        tick();
        rst = 1'b0;
        chk("reset in_ready", 32'(in_ready), 32'd1);
        chk("reset out_valid", 32'(out_valid), 32'd0);
        chk("reset h", 32'(h), 32'd0);
        chk("reset max_index", 32'(max_index), 32'd0);
        chk("reset v_max", 32'(v_max), 32'd0);
        chk("reset delta", 32'(delta), 32'd0);

        for (int i = 0; i < 12; i++) begin
            run_pixel(tbl[i], $sformatf("vec%0d", i),
                      (i == 6) ? 5 : 0, (i == 6) ? 3 : 0, (i == 2) ? 5 : 0);
        end

        // Reset at step 7 of DIVIDE discards the pending pixel
        r = 8'd255; g = 8'd0; b = 8'd128;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        for (int k = 0; k < 7; k++) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("midrst out_valid", 32'(out_valid), 32'd0);
        chk("midrst in_ready", 32'(in_ready), 32'd1);
        chk("midrst h", 32'(h), 32'd0);
        chk("midrst max_index", 32'(max_index), 32'd0);
        chk("midrst v_max", 32'(v_max), 32'd0);
        chk("midrst delta", 32'(delta), 32'd0);
        run_pixel(tbl[5], "after_rst", 0, 0, 0);

        for (int i = 0; i < 16; i++) begin
            rv.r = 8'($urandom_range(255));
            rv.g = 8'($urandom_range(255));
            rv.b = 8'($urandom_range(255));
            rv.e = model(rv.r, rv.g, rv.b);
            run_pixel(rv, $sformatf("rand%0d", i), 0, 0, 0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
